// File: rtl/stage_mem_sb.sv
`default_nettype none
// ============================================================================
// Module      : stage_mem_sb
// Description : Store-buffered MEM stage. It aligns stores into byte lanes and
//               queues them for background drain. Loads are forwarded from the
//               queue or read from memory, and are returned sign/zero-extended.
//               Optional macro MEM_MISALIGN_TRAP_EN flags and suppresses
//               misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_mem_sb #(
    parameter int XLEN     = 32,
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                me_valid,
    input  logic                me_mem_read,
    input  logic                me_mem_write,
    input  logic [2:0]          me_func3_code,
    input  logic [ADDR_W-1:0]   me_alu_o,
    input  logic [XLEN-1:0]     me_regs_data2,
    input  logic                forward_data,
    input  logic [XLEN-1:0]     w_regs_data,
    input  logic                me_fence,
    output logic                me_stall,
    output logic                me_load_valid,
    output logic [XLEN-1:0]     me_load_data,
    output logic                me_misalign,
    output logic                dm_req,
    output logic                dm_we,
    output logic [XLEN/8-1:0]   dm_be,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [XLEN-1:0]     dm_wdata,
    input  logic                dm_gnt,
    input  logic                dm_rvalid,
    input  logic [XLEN-1:0]     dm_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int PW   = $clog2(SB_DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LD_REQ  = 2'd1,
        S_LD_WAIT = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_head, r_tail;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
    logic [NB-1:0]     r_sb_be   [SB_DEPTH];
    logic [XLEN-1:0]   r_sb_data [SB_DEPTH];

    logic [OFFW-1:0]   w_off, w_mask, w_lane;
    logic [NB-1:0]     w_be_base, w_be;
    logic [XLEN-1:0]   w_st_data, w_st_lanes;
    logic [XLEN-1:0]   w_raw, w_sh, w_ext_mask, w_ext;
    logic              w_sign, w_sz_ok, w_mis, w_acc_ok;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_ld, w_st, w_full, w_fence_hold;
    logic              w_hit, w_fwd, w_ld_issue, w_drain, w_ld_done;
    logic              w_push, w_pop;
    logic [PW-1:0]     w_hit_idx;

    // Lane alignment: low offset bits below the access size are dropped.
    always_comb begin
        w_off     = me_alu_o[OFFW-1:0];
        w_st_data = forward_data ? w_regs_data : me_regs_data2;
        w_sz_ok   = 1'b1;
        case (me_func3_code[1:0])
            2'b00: begin
                w_mask = '0;          w_be_base = NB'(1);
                w_st_lanes = {NB{w_st_data[7:0]}};
            end
            2'b01: begin
                w_mask = OFFW'(1);    w_be_base = NB'(3);
                w_st_lanes = {(NB/2){w_st_data[15:0]}};
            end
            2'b10: begin
                w_mask = OFFW'(3);    w_be_base = NB'(15);
                w_st_lanes = {(NB/4){w_st_data[31:0]}};
            end
            default: begin
                w_mask = '1;          w_be_base = '1;
                w_st_lanes = w_st_data;
                w_sz_ok = (XLEN == 64);
            end
        endcase
        w_lane = w_off & ~w_mask;
        w_be   = w_be_base << w_lane;
    end

    assign w_word_addr = {me_alu_o[ADDR_W-1:OFFW], {OFFW{1'b0}}};

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis    = me_valid & (me_mem_read | me_mem_write) & ((|(w_off & w_mask)) | ~w_sz_ok);
    assign w_acc_ok = ~w_mis;
`else
    assign w_mis    = 1'b0;
    assign w_acc_ok = w_sz_ok;
`endif

    assign w_ld         = me_valid & me_mem_read  & w_acc_ok;
    assign w_st         = me_valid & me_mem_write & w_acc_ok;
    assign w_full       = (r_count == CW'(SB_DEPTH));
    assign w_fence_hold = me_fence & (r_count != '0);

    // Scan oldest to youngest so the last match is the youngest overlap.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = r_head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CW'(i) < r_count) &&
                (r_sb_addr[r_head + PW'(i)] == w_word_addr) &&
                (|(r_sb_be[r_head + PW'(i)] & w_be))) begin
                w_hit     = 1'b1;
                w_hit_idx = r_head + PW'(i);
            end
        end
    end

    assign w_fwd      = w_hit & ((r_sb_be[w_hit_idx] & w_be) == w_be);
    assign w_ld_issue = ((r_state == S_IDLE) & w_ld & ~w_hit) | (r_state == S_LD_REQ);
    assign w_drain    = (r_state == S_IDLE) & ~w_ld_issue & (r_count != '0);
    assign w_ld_done  = ((r_state == S_LD_WAIT) & dm_rvalid) |
                        ((r_state == S_IDLE) & w_ld & w_fwd);
    assign w_push     = w_st & ~w_full & ~w_fence_hold;
    assign w_pop      = w_drain & dm_gnt;

    // Result extension: mask to the access width, then fill with the sign bit.
    always_comb begin
        w_raw = (r_state == S_LD_WAIT) ? dm_rdata : r_sb_data[w_hit_idx];
        w_sh  = w_raw >> {w_lane, 3'b000};
        case (me_func3_code[1:0])
            2'b00:   begin w_ext_mask = XLEN'(8'hFF);         w_sign = w_sh[7];  end
            2'b01:   begin w_ext_mask = XLEN'(16'hFFFF);      w_sign = w_sh[15]; end
            2'b10:   begin w_ext_mask = XLEN'(32'hFFFF_FFFF); w_sign = w_sh[31]; end
            default: begin w_ext_mask = '1;                   w_sign = 1'b0;     end
        endcase
        w_ext = (w_sh & w_ext_mask) | ((w_sign & ~me_func3_code[2]) ? ~w_ext_mask : '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_ld & ~w_hit) w_state_nxt = dm_gnt ? S_LD_WAIT : S_LD_REQ;
            S_LD_REQ:  if (dm_gnt)        w_state_nxt = S_LD_WAIT;
            S_LD_WAIT: if (dm_rvalid)     w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_sb_addr[r_tail] <= w_word_addr;
                r_sb_be[r_tail]   <= w_be;
                r_sb_data[r_tail] <= w_st_lanes;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        me_stall      = 1'b0;
        me_load_valid = 1'b0;
        me_load_data  = '0;
        me_misalign   = 1'b0;
        dm_req        = 1'b0;
        dm_we         = 1'b0;
        dm_be         = '0;
        dm_addr       = '0;
        dm_wdata      = '0;
        if (rstn) begin
            me_misalign   = w_mis;
            me_load_valid = w_ld_done;
            me_load_data  = w_ld_done ? w_ext : '0;
            me_stall      = me_valid & ((w_st & w_full) | (w_ld & ~w_ld_done) | w_fence_hold);
            if (w_drain) begin
                dm_req   = 1'b1;
                dm_we    = 1'b1;
                dm_be    = r_sb_be[r_head];
                dm_addr  = r_sb_addr[r_head];
                dm_wdata = r_sb_data[r_head];
            end else if (w_ld_issue) begin
                dm_req   = 1'b1;
                dm_be    = w_be;
                dm_addr  = w_word_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_mem_sb
// Description : Directed scoreboard bench for stage_mem_sb with a simple
//               grant/rvalid memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_mem_sb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        me_valid = 1'b0, me_mem_read = 1'b0, me_mem_write = 1'b0;
    logic [2:0]  me_func3_code = 3'b0;
    logic [31:0] me_alu_o = '0, me_regs_data2 = '0, w_regs_data = '0;
    logic        forward_data = 1'b0, me_fence = 1'b0;
    logic        me_stall, me_load_valid, me_misalign;
    logic [31:0] me_load_data;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    always #5 clk = ~clk;

    stage_mem_sb #(.XLEN(32), .SB_DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .me_valid(me_valid), .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
        .me_func3_code(me_func3_code), .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2),
        .forward_data(forward_data), .w_regs_data(w_regs_data), .me_fence(me_fence),
        .me_stall(me_stall), .me_load_valid(me_load_valid), .me_load_data(me_load_data),
        .me_misalign(me_misalign),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
    );

    // Memory model
    logic        gnt_wr_en = 1'b1, gnt_rd_en = 1'b1, rv_en = 1'b1, mem_init = 1'b1;
    logic        pend = 1'b0;
    logic [31:0] rdata_r;
    logic [31:0] mem [0:511];

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    assign dm_gnt    = dm_req & (dm_we ? gnt_wr_en : gnt_rd_en);
    assign dm_rvalid = pend & rv_en;
    assign dm_rdata  = rdata_r;

    always @(posedge clk) begin
        if (mem_init) begin
            mem[9'h040] <= 32'h1234_5678;
            mem[9'h080] <= 32'h8000_0000;
            pend        <= 1'b0;
        end else begin
            if (dm_rvalid) pend <= 1'b0;
            if (dm_req && dm_gnt) begin
                if (dm_we) mem[dm_addr[10:2]] <= merge(mem[dm_addr[10:2]], dm_wdata, dm_be);
                else begin
                    pend    <= 1'b1;
                    rdata_r <= mem[dm_addr[10:2]];
                end
            end
        end
    end

    // Scoreboard
    int          n_total = 0, n_pass = 0, n_rdreq = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    initial begin : monitor
        logic        p_req, p_gnt, p_we;
        logic [3:0]  p_be;
        logic [31:0] p_addr, p_wdata, e;
        p_req = 1'b0; p_gnt = 1'b0; p_we = 1'b0; p_be = '0; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (me_load_valid) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_load: got 0x%08h, expected no load result", me_load_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("load_data", me_load_data, e);
                    end
                end
                if (p_req && !p_gnt && (p_we == dm_we)) begin
                    check("dm_hold_addr", dm_addr, p_addr);
                    check("dm_hold_req_be", {27'b0, dm_req, dm_be}, {27'b0, 1'b1, p_be});
                    if (p_we) check("dm_hold_wdata", dm_wdata, p_wdata);
                end
                if (dm_req && !dm_we) n_rdreq++;
                p_req = dm_req; p_gnt = dm_gnt; p_we = dm_we;
                p_be = dm_be; p_addr = dm_addr; p_wdata = dm_wdata;
            end else begin
                p_req = 1'b0;
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input bit fe, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, output int stalls);
        me_valid = 1'b1; me_mem_read = rd; me_mem_write = wr; me_fence = fe;
        me_func3_code = f3; me_alu_o = a; me_regs_data2 = d;
        stalls = 0;
        @(negedge clk);
        while (me_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (me_stall) begin
            n_total++;
            $display("FAIL stall_timeout: still stalled after %0d cycles, expected release", stalls);
        end
        @(posedge clk); #1;
        me_valid = 1'b0; me_mem_read = 1'b0; me_mem_write = 1'b0; me_fence = 1'b0;
    endtask

    initial begin : main
        int s, s_sum, r0;
        logic any_req;

        // Reset gating: a live load request must not leak through
        me_valid = 1'b1; me_mem_read = 1'b1; me_func3_code = 3'b010; me_alu_o = 32'h100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall_req", {30'b0, me_stall, dm_req}, 32'h0);
        check("rst_valid_mis", {30'b0, me_load_valid, me_misalign}, 32'h0);
        me_valid = 1'b0; me_mem_read = 1'b0; mem_init = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        // SB then LBU: forwarded, no stall, no read
        issue(0, 1, 0, 3'b000, 32'h101, 32'h0000_00AB, s);
        check("sb_stalls", s, 0);
        r0 = n_rdreq;
        exp_q.push_back(32'h0000_00AB);
        issue(1, 0, 0, 3'b100, 32'h101, 32'h0, s);
        check("lbu_fwd_stalls", s, 0);
        check("lbu_fwd_noread", n_rdreq - r0, 0);

        // SH then LW: partial overlap, wait for pop, then read
        issue(0, 1, 0, 3'b001, 32'h100, 32'h0000_8001, s);
        exp_q.push_back(32'h1234_8001);
        issue(1, 0, 0, 3'b010, 32'h100, 32'h0, s);
        check("lw_partial_stalls", s, 2);

        // Fill the buffer with no write grants, fifth store waits for a pop
        gnt_wr_en = 1'b0;
        s_sum = 0;
        issue(0, 1, 0, 3'b010, 32'h300, 32'h1111_1111, s); s_sum += s;
        issue(0, 1, 0, 3'b010, 32'h304, 32'h2222_2222, s); s_sum += s;
        forward_data = 1'b1; w_regs_data = 32'h3333_3333;
        issue(0, 1, 0, 3'b010, 32'h308, 32'hDEAD_BEEF, s); s_sum += s;
        forward_data = 1'b0;
        issue(0, 1, 0, 3'b010, 32'h30C, 32'h4444_4444, s); s_sum += s;
        check("fill_stalls", s_sum, 0);
        fork
            begin repeat (3) @(posedge clk); #1 gnt_wr_en = 1'b1; end
        join_none
        issue(0, 1, 0, 3'b010, 32'h310, 32'h5555_5555, s);
        check("full_sw_stalls", s, 4);
        exp_q.push_back(32'h5555_5555);
        issue(1, 0, 0, 3'b010, 32'h310, 32'h0, s);
        check("lw_fwd_full_stalls", s, 0);
        repeat (6) @(posedge clk);
        #1;
        exp_q.push_back(32'h2222_2222);
        issue(1, 0, 0, 3'b010, 32'h304, 32'h0, s);
        check("lw_mem_stalls", s, 1);
        exp_q.push_back(32'h3333_3333);
        issue(1, 0, 0, 3'b010, 32'h308, 32'h0, s);

        // Sign/zero extension from memory word 0x80000000
        exp_q.push_back(32'hFFFF_FF80);
        issue(1, 0, 0, 3'b000, 32'h203, 32'h0, s);
        check("lb_stalls", s, 1);
        exp_q.push_back(32'h0000_0080);
        issue(1, 0, 0, 3'b100, 32'h203, 32'h0, s);
        exp_q.push_back(32'hFFFF_8000);
        issue(1, 0, 0, 3'b001, 32'h202, 32'h0, s);
        exp_q.push_back(32'h0000_8000);
        issue(1, 0, 0, 3'b101, 32'h202, 32'h0, s);

        // Fence holds until the queued store drains
        gnt_wr_en = 1'b0;
        issue(0, 1, 0, 3'b010, 32'h600, 32'h0000_0066, s);
        fork
            begin repeat (2) @(posedge clk); #1 gnt_wr_en = 1'b1; end
        join_none
        issue(0, 0, 1, 3'b000, 32'h0, 32'h0, s);
        check("fence_stalls", s, 3);

        // Reset with a read outstanding and two stores queued
        gnt_wr_en = 1'b0;
        issue(0, 1, 0, 3'b010, 32'h400, 32'h0000_0001, s);
        issue(0, 1, 0, 3'b010, 32'h404, 32'h0000_0002, s);
        rv_en = 1'b0;
        me_valid = 1'b1; me_mem_read = 1'b1; me_func3_code = 3'b010; me_alu_o = 32'h500;
        @(negedge clk);
        check("rst_rd_issue", {30'b0, dm_req, dm_we}, 32'h2);
        @(posedge clk); #1;
        me_valid = 1'b0; me_mem_read = 1'b0; rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1; rv_en = 1'b1; gnt_wr_en = 1'b1;
        @(negedge clk);
        check("rst_rvalid_ignored", {31'b0, me_load_valid}, 32'h0);
        any_req = dm_req;
        repeat (3) begin
            @(negedge clk);
            any_req = any_req | dm_req;
        end
        check("rst_no_drain", {31'b0, any_req}, 32'h0);
        @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
        me_valid = 1'b1; me_mem_read = 1'b1; me_func3_code = 3'b010; me_alu_o = 32'h102;
        @(negedge clk);
        check("mis_flag", {31'b0, me_misalign}, 32'h1);
        check("mis_suppress", {29'b0, dm_req, me_stall, me_load_valid}, 32'h0);
        @(posedge clk); #1;
        me_valid = 1'b0; me_mem_read = 1'b0;
`else
        exp_q.push_back(32'h1234_8001);
        issue(1, 0, 0, 3'b010, 32'h102, 32'h0, s);
        check("lw_trunc_stalls", s, 1);
`endif

        repeat (2) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
